// File: rtl/rv32v_opi_sequencer.sv
// OPI vector op sequencer: accepts one decoded op, then walks 0..vl-1 in
// LANES-wide element groups, emitting one masked beat per accept.

module rv32v_opi_lane #(
    parameter int LANE = 0,
    parameter int VLW  = 6
) (
    input  logic [VLW-1:0] base,
    input  logic [VLW-1:0] vl,
    input  logic           v0_bit,
    input  logic           unmasked,
    output logic           en
);
    logic [VLW-1:0] idx;

    assign idx = base + VLW'(LANE);
    assign en  = (idx < vl) && (unmasked || v0_bit);
endmodule

module rv32v_opi_sequencer #(
    parameter int LANES = 4,
    parameter int VLMAX = 32,
    parameter int OPW   = 5,
    parameter int VLW   = $clog2(VLMAX + 1)
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             issue_valid,
    output logic             issue_ready,
    input  logic             issue_op_valid,
    input  logic [1:0]       issue_vfu,
    input  logic [OPW-1:0]   issue_valuop,
    input  logic             issue_unsigned,
    input  logic             issue_disable_mask,
    input  logic             issue_vm,
    input  logic [VLW-1:0]   issue_vl,
    input  logic [VLMAX-1:0] issue_v0,
    input  logic             flush,
    output logic             ex_valid,
    input  logic             ex_ready,
    output logic [1:0]       ex_vfu,
    output logic [OPW-1:0]   ex_valuop,
    output logic             ex_unsigned,
    output logic [VLW-1:0]   ex_eidx,
    output logic [LANES-1:0] ex_lane_en,
    output logic             ex_last,
    output logic             done,
    output logic             illegal
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t state_q, state_d;

    logic [VLW-1:0]   vl_q;
    logic [VLMAX-1:0] v0_q;
    logic             vm_q, dm_q;

    logic             hs;
    logic [VLW-1:0]   vl_clamp;
    logic [VLW-1:0]   src_base, src_vl;
    logic [VLMAX-1:0] src_v0;
    logic             src_unmasked;
    logic [LANES-1:0] v0_win;
    logic [LANES-1:0] en_nxt;
    logic [VLW:0]     end_idx;
    logic             last_nxt;

    assign issue_ready = (state_q == IDLE);
    assign hs          = issue_valid && issue_ready && !flush;
    assign vl_clamp    = (issue_vl > VLW'(VLMAX)) ? VLW'(VLMAX) : issue_vl;

    // Next-beat lane/last values come from the issue port on a handshake and
    // from the captured op while advancing, so ex_* are always registered.
    assign src_base     = (state_q == IDLE) ? '0 : ex_eidx + VLW'(LANES);
    assign src_vl       = (state_q == IDLE) ? vl_clamp : vl_q;
    assign src_v0       = (state_q == IDLE) ? issue_v0 : v0_q;
    assign src_unmasked = (state_q == IDLE) ? (issue_vm || issue_disable_mask)
                                            : (vm_q || dm_q);
    assign v0_win       = LANES'(src_v0 >> src_base);
    assign end_idx      = {1'b0, src_base} + (VLW+1)'(LANES);
    assign last_nxt     = end_idx >= {1'b0, src_vl};

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        rv32v_opi_lane #(.LANE(g), .VLW(VLW)) u_lane (
            .base     (src_base),
            .vl       (src_vl),
            .v0_bit   (v0_win[g]),
            .unmasked (src_unmasked),
            .en       (en_nxt[g])
        );
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (hs && issue_op_valid) state_d = (issue_vl == '0) ? DONE : BUSY;
            BUSY: begin
                if (flush)                    state_d = IDLE;
                else if (ex_ready && ex_last) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ex_valid    <= 1'b0;
            ex_vfu      <= '0;
            ex_valuop   <= '0;
            ex_unsigned <= 1'b0;
            ex_eidx     <= '0;
            ex_lane_en  <= '0;
            ex_last     <= 1'b0;
            done        <= 1'b0;
            illegal     <= 1'b0;
            vl_q        <= '0;
            v0_q        <= '0;
            vm_q        <= 1'b0;
            dm_q        <= 1'b0;
        end else begin
            done    <= 1'b0;
            illegal <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (hs && !issue_op_valid) begin
                        illegal <= 1'b1;
                    end else if (hs) begin
                        ex_vfu      <= issue_vfu;
                        ex_valuop   <= issue_valuop;
                        ex_unsigned <= issue_unsigned;
                        vl_q        <= vl_clamp;
                        v0_q        <= issue_v0;
                        vm_q        <= issue_vm;
                        dm_q        <= issue_disable_mask;
                        ex_eidx     <= '0;
                        if (issue_vl == '0) begin
                            done <= 1'b1;
                        end else begin
                            ex_valid   <= 1'b1;
                            ex_lane_en <= en_nxt;
                            ex_last    <= last_nxt;
                        end
                    end
                end
                BUSY: begin
                    if (flush) begin
                        ex_valid   <= 1'b0;
                        ex_lane_en <= '0;
                        ex_last    <= 1'b0;
                    end else if (ex_ready && ex_last) begin
                        ex_valid   <= 1'b0;
                        ex_lane_en <= '0;
                        ex_last    <= 1'b0;
                        done       <= 1'b1;
                    end else if (ex_ready) begin
                        ex_eidx    <= src_base;
                        ex_lane_en <= en_nxt;
                        ex_last    <= last_nxt;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_rv32v_opi_sequencer.sv
// Scoreboard bench for rv32v_opi_sequencer: the driver pushes expected beats
// and completion events; a negedge monitor pops and compares on every accept.

module tb_rv32v_opi_sequencer;
    localparam int LANES = 4;
    localparam int VLMAX = 32;
    localparam int OPW   = 5;
    localparam int VLW   = $clog2(VLMAX + 1);

    logic             CLK, nRST;
    logic             issue_valid, issue_ready, issue_op_valid;
    logic [1:0]       issue_vfu;
    logic [OPW-1:0]   issue_valuop;
    logic             issue_unsigned, issue_disable_mask, issue_vm;
    logic [VLW-1:0]   issue_vl;
    logic [VLMAX-1:0] issue_v0;
    logic             flush;
    logic             ex_valid, ex_ready;
    logic [1:0]       ex_vfu;
    logic [OPW-1:0]   ex_valuop;
    logic             ex_unsigned;
    logic [VLW-1:0]   ex_eidx;
    logic [LANES-1:0] ex_lane_en;
    logic             ex_last, done, illegal;

    rv32v_opi_sequencer #(.LANES(LANES), .VLMAX(VLMAX), .OPW(OPW)) dut (
        .CLK(CLK), .nRST(nRST),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_op_valid(issue_op_valid), .issue_vfu(issue_vfu),
        .issue_valuop(issue_valuop), .issue_unsigned(issue_unsigned),
        .issue_disable_mask(issue_disable_mask), .issue_vm(issue_vm),
        .issue_vl(issue_vl), .issue_v0(issue_v0), .flush(flush),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_vfu(ex_vfu),
        .ex_valuop(ex_valuop), .ex_unsigned(ex_unsigned), .ex_eidx(ex_eidx),
        .ex_lane_en(ex_lane_en), .ex_last(ex_last), .done(done), .illegal(illegal)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        int               eidx;
        logic [LANES-1:0] en;
        logic             last;
        logic [1:0]       vfu;
        logic [OPW-1:0]   op;
        logic             uns;
    } beat_t;

    beat_t exp_q[$];
    int    evt_q[$];   // 1 = done, 2 = illegal
    int    tests = 0;
    int    fails = 0;
    int    ready_pct = 100;
    int    hold_low = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: the op expands to ceil(min(vl,VLMAX)/LANES) beats, element e
    // enabled iff e < vl and (disable_mask or vm or v0[e]), then one done.
    task automatic push_model(input bit ov, input logic [1:0] vfu, input logic [OPW-1:0] op,
                              input bit uns, input bit dm, input bit vm, input int vl,
                              input logic [VLMAX-1:0] v0);
        int vlc, nb, e;
        beat_t x;
        if (!ov) begin
            evt_q.push_back(2);
            return;
        end
        vlc = (vl > VLMAX) ? VLMAX : vl;
        nb  = (vlc + LANES - 1) / LANES;
        for (int b = 0; b < nb; b++) begin
            x.eidx = b * LANES;
            for (int i = 0; i < LANES; i++) begin
                e = x.eidx + i;
                x.en[i] = (e < vlc) ? (dm || vm || v0[e]) : 1'b0;
            end
            x.last = (b == nb - 1);
            x.vfu  = vfu;
            x.op   = op;
            x.uns  = uns;
            exp_q.push_back(x);
        end
        evt_q.push_back(1);
    endtask

    task automatic issue(input bit ov, input logic [1:0] vfu, input logic [OPW-1:0] op,
                         input bit uns, input bit dm, input bit vm, input int vl,
                         input logic [VLMAX-1:0] v0);
        int n = 0;
        while (!issue_ready && n < 200) begin
            @(posedge CLK); #1; n++;
        end
        if (!issue_ready) begin
            tests++; fails++;
            $display("FAIL issue_timeout: issue_ready stayed 0 for %0d cycles", n);
            return;
        end
        issue_op_valid = ov; issue_vfu = vfu; issue_valuop = op; issue_unsigned = uns;
        issue_disable_mask = dm; issue_vm = vm; issue_vl = VLW'(vl); issue_v0 = v0;
        issue_valid = 1'b1;
        push_model(ov, vfu, op, uns, dm, vm, vl, v0);
        @(posedge CLK); #1;
        issue_valid = 1'b0;
        if (ov && vl > 0) begin
            chk("first_beat_valid", ex_valid, 1);
            chk("first_beat_eidx", ex_eidx, 0);
        end else begin
            chk("no_beat_valid", ex_valid, 0);
        end
        if (!ov) chk("ready_after_illegal", issue_ready, 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(posedge CLK); #1; n++;
        end while (!(exp_q.size() == 0 && evt_q.size() == 0 && issue_ready) && n < 500);
        if (!(exp_q.size() == 0 && evt_q.size() == 0 && issue_ready)) begin
            tests++; fails++;
            $display("FAIL op_timeout: %0d beats, %0d events still pending", exp_q.size(), evt_q.size());
            exp_q.delete(); evt_q.delete();
        end
    endtask

    // ready driver: optional forced-low window while a beat is presented
    initial begin
        ex_ready = 1'b0;
        forever begin
            @(posedge CLK); #1;
            if (hold_low > 0 && ex_valid) begin
                ex_ready = 1'b0;
                hold_low--;
            end else begin
                ex_ready = ($urandom_range(0, 99) < ready_pct);
            end
        end
    end

    // monitor
    bit               stall, done_due, rdy_due;
    logic [VLW-1:0]   s_eidx;
    logic [LANES-1:0] s_en;
    logic             s_last;
    logic [OPW-1:0]   s_op;
    initial begin
        beat_t b;
        int    ev;
        stall = 0; done_due = 0; rdy_due = 0;
        forever begin
            @(negedge CLK);
            if (!nRST) begin
                stall = 0; done_due = 0; rdy_due = 0;
            end else begin
                if (stall) begin
                    chk("hold_valid", ex_valid, 1);
                    chk("hold_eidx", ex_eidx, s_eidx);
                    chk("hold_lane_en", ex_lane_en, s_en);
                    chk("hold_last", ex_last, s_last);
                    chk("hold_valuop", ex_valuop, s_op);
                end
                if (rdy_due) begin
                    chk("ready_after_done", issue_ready, 1);
                    rdy_due = 0;
                end
                if (done_due) begin
                    chk("done_latency", done, 1);
                    done_due = 0;
                    rdy_due  = 1;
                end
                if (ex_valid && ex_ready && !flush) begin
                    if (exp_q.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL unexpected_beat: eidx=%0d, want no beat", ex_eidx);
                    end else begin
                        b = exp_q.pop_front();
                        chk("beat_eidx", ex_eidx, b.eidx);
                        chk("beat_lane_en", ex_lane_en, b.en);
                        chk("beat_last", ex_last, b.last);
                        chk("beat_vfu", ex_vfu, b.vfu);
                        chk("beat_valuop", ex_valuop, b.op);
                        chk("beat_unsigned", ex_unsigned, b.uns);
                        if (ex_last) done_due = 1;
                    end
                end
                if (done || illegal) begin
                    if (evt_q.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL unexpected_event: done=%0b illegal=%0b, want none", done, illegal);
                    end else begin
                        ev = evt_q.pop_front();
                        chk("event_kind", {done, illegal}, (ev == 1) ? 2'b10 : 2'b01);
                    end
                end
                stall  = ex_valid && !ex_ready && !flush;
                s_eidx = ex_eidx; s_en = ex_lane_en; s_last = ex_last; s_op = ex_valuop;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        nRST = 1'b0; issue_valid = 0; issue_op_valid = 0; issue_vfu = 0; issue_valuop = 0;
        issue_unsigned = 0; issue_disable_mask = 0; issue_vm = 0; issue_vl = 0; issue_v0 = 0;
        flush = 0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_issue_ready", issue_ready, 1);
        chk("rst_ex_valid", ex_valid, 0);
        chk("rst_ex_eidx", ex_eidx, 0);
        chk("rst_ex_lane_en", ex_lane_en, 0);
        chk("rst_ex_last", ex_last, 0);
        chk("rst_done_illegal", {done, illegal}, 0);
        chk("rst_ex_fields", {ex_vfu, ex_valuop, ex_unsigned}, 0);
        nRST = 1'b1;
        @(posedge CLK); #1;

        // basic walk, tail in last group
        ready_pct = 100;
        issue(1, 2'd1, 5'd3, 0, 0, 1, 10, '0);              wait_idle();
        // v0 masking, then the mask-disable class
        issue(1, 2'd2, 5'd7, 1, 0, 0, 8, 32'h0000_00A5);    wait_idle();
        issue(1, 2'd2, 5'd7, 1, 1, 0, 8, 32'h0000_00A5);    wait_idle();
        // backpressure on the first beat
        hold_low = 3;
        issue(1, 2'd0, 5'd1, 0, 0, 1, 8, '0);               wait_idle();
        // corner ops
        issue(0, 2'd3, 5'd9, 0, 0, 1, 12, '0);              wait_idle();
        issue(1, 2'd1, 5'd2, 0, 0, 1, 0, '0);               wait_idle();
        issue(1, 2'd1, 5'd4, 0, 0, 1, 40, '0);              wait_idle();

        // flush on the second beat of vl=16
        issue(1, 2'd3, 5'd5, 0, 0, 1, 16, '0);
        n = 0;
        while (!(ex_valid && ex_eidx == 4) && n < 50) begin
            @(posedge CLK); #1; n++;
        end
        chk("flush_reached_beat1", {ex_valid, ex_eidx}, {1'b1, 6'd4});
        flush = 1'b1;
        exp_q.delete(); evt_q.delete();
        @(posedge CLK); #1;
        flush = 1'b0;
        chk("flush_ex_valid", ex_valid, 0);
        chk("flush_issue_ready", issue_ready, 1);
        repeat (4) @(posedge CLK);
        #1;
        issue(1, 2'd0, 5'd6, 1, 0, 0, 7, 32'h0000_0055);    wait_idle();

        // asynchronous reset mid-op
        ready_pct = 0;
        issue(1, 2'd2, 5'd8, 0, 0, 1, 32, '0);
        @(posedge CLK); #3;
        nRST = 1'b0;
        #1;
        chk("arst_ex_valid", ex_valid, 0);
        chk("arst_issue_ready", issue_ready, 1);
        chk("arst_ex_eidx", ex_eidx, 0);
        chk("arst_lane_en_last", {ex_lane_en, ex_last}, 0);
        chk("arst_done_illegal", {done, illegal}, 0);
        exp_q.delete(); evt_q.delete();
        #10 nRST = 1'b1;
        @(posedge CLK); #1;
        ready_pct = 100;
        issue(1, 2'd1, 5'd11, 0, 0, 1, 12, '0);             wait_idle();

        // randomized ops with random backpressure
        for (int k = 0; k < 40; k++) begin
            ready_pct = (k % 3 == 0) ? 100 : $urandom_range(25, 90);
            issue(($urandom_range(0, 9) != 0), 2'($urandom), 5'($urandom), 1'($urandom),
                  1'($urandom), 1'($urandom), $urandom_range(0, 40), 32'($urandom));
            wait_idle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
